// File: rtl/mul_div_unit.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Latency: WIDTH+1 edges from accepting start to done (2 edges for divide by zero).
// Backpressure: none; start is ignored while busy, and results hold until the next completion.
module mul_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    // Datapath for one iteration; hi_q/lo_q hold {partial product, multiplier}
    // for multiply and {partial remainder, dividend/quotient} for divide.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_rem   = div_shift[WIDTH-1:0] - opb_q;
        if (op_q) begin
            step_hi = div_ge ? div_rem : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    opb_d   = b;
                    hi_d    = '0;
                    lo_d    = a;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (op_q && (opb_q == '0)) begin
                    // Divide by zero: no iterations, dividend passes through as remainder.
                    res_lo_d = '1;
                    res_hi_d = lo_q;
                    dbz_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        res_lo_d = step_lo;
                        res_hi_d = step_hi;
                        dbz_d    = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign dbz       = dbz_q;

endmodule
